ctr_round_scheduler: RTL and testbench

Arbitrates between two player requesters for the single shared counter datapath.
- Sequences that counter's control code, initial value and INIT load pulse, one time-slice per granted request.
- Counts completed rounds and flags game end after MAX_ROUNDS slices.
- Sits directly in front of the counter instance; its control, initial_value and INIT outputs connect 1:1 to the counter inputs of the same names.

---
 rtl/ctr_game_pkg.sv | 21 ++
 rtl/ctr_rr_arb2.sv | 44 ++++
 rtl/ctr_round_scheduler.sv | 152 +++++++++++++++
 tb/tb_ctr_round_scheduler.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctr_game_pkg.sv
// Shared types for the counter round scheduler: FSM states and control codes.
// Build option: CTR_SCHED_FIXED_PRIO_EN (fixed player-0 priority, no pointer).
package ctr_game_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  typedef logic [1:0] ctrl_t;

  localparam ctrl_t CTRL_IDLE   = 2'b00;
  localparam ctrl_t CTRL_MODE_1 = 2'b01;
  localparam ctrl_t CTRL_MODE_2 = 2'b10;
  localparam ctrl_t CTRL_MODE_3 = 2'b11;

  localparam ctrl_t IDLE_CODE_DEF = CTRL_IDLE;

endpackage

// File: rtl/ctr_rr_arb2.sv
// Two-requester arbiter; the pointer flips each time a slice completes.
// Build option: CTR_SCHED_FIXED_PRIO_EN reduces it to fixed player-0 priority.
module ctr_rr_arb2 (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] pick
);

`ifdef CTR_SCHED_FIXED_PRIO_EN

  // Player 0 always wins a tie.
  always_comb begin
    pick = 2'b00;
    if (req[0])
      pick = 2'b01;
    else if (req[1])
      pick = 2'b10;
  end

`else

  logic ptr;

  // Pointer: 0 favours player 0, 1 favours player 1.
  always_ff @(posedge clock) begin
    if (reset)
      ptr <= 1'b0;
    else if (advance)
      ptr <= ~ptr;
  end

  // Sole requester wins; a tie goes to the favoured player.
  always_comb begin
    unique case (req)
      2'b11:   pick = ptr ? 2'b10 : 2'b01;
      default: pick = req;
    endcase
  end

`endif

endmodule

// File: rtl/ctr_round_scheduler.sv
// Time-slices the shared counter between two players for a fixed number of rounds.
// Build option: CTR_SCHED_FIXED_PRIO_EN selects fixed priority in ctr_rr_arb2.
module ctr_round_scheduler
  import ctr_game_pkg::*;
#(
  parameter int    SLICE_CYCLES = 16,
  parameter int    INIT_CYCLES  = 2,
  parameter int    MAX_ROUNDS   = 8,
  parameter ctrl_t IDLE_CODE    = IDLE_CODE_DEF,
  localparam int   RW = $clog2(MAX_ROUNDS + 1)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [1:0]    req,
  input  logic [1:0]    req_mode_0,
  input  logic [1:0]    req_mode_1,
  input  logic [1:0]    req_load,
  input  logic [3:0]    req_value_0,
  input  logic [3:0]    req_value_1,
  output logic [1:0]    grant,
  output logic [1:0]    control,
  output logic [3:0]    initial_value,
  output logic          INIT,
  output logic          busy,
  output logic          owner,
  output logic [RW-1:0] round_count,
  output logic          game_done
);

  localparam int CMAX = (INIT_CYCLES > SLICE_CYCLES) ?
                        INIT_CYCLES : SLICE_CYCLES;
  localparam int CW = $clog2(CMAX + 1);

  localparam logic [CW-1:0] LOAD_LAST = CW'(INIT_CYCLES - 1);
  localparam logic [CW-1:0] RUN_LAST  = CW'(SLICE_CYCLES - 1);
  localparam logic [RW-1:0] LAST_RND  = RW'(MAX_ROUNDS - 1);

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  ctrl_t         mode_q, mode_n;
  logic [3:0]    val_q, val_n;
  logic          load_n;
  logic [1:0]    pick;
  logic          advance;
  logic          take;

  logic [1:0]    grant_d;
  ctrl_t         control_d;
  logic [3:0]    iv_d;
  logic          init_d;
  logic          busy_d;
  logic          owner_d;
  logic [RW-1:0] rc_d;
  logic          done_d;

  ctr_rr_arb2 u_arb (
    .clock   (clock),
    .reset   (reset),
    .req     (req),
    .advance (advance),
    .pick    (pick)
  );

  assign take = (state == IDLE) && (|pick);

  // State, slice counter, latched request and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      cnt           <= '0;
      mode_q        <= IDLE_CODE;
      val_q         <= '0;
      grant         <= '0;
      control       <= IDLE_CODE;
      initial_value <= '0;
      INIT          <= 1'b0;
      busy          <= 1'b0;
      owner         <= 1'b0;
      round_count   <= '0;
      game_done     <= 1'b0;
    end else begin
      state         <= state_n;
      cnt           <= cnt_n;
      mode_q        <= mode_n;
      val_q         <= val_n;
      grant         <= grant_d;
      control       <= control_d;
      initial_value <= iv_d;
      INIT          <= init_d;
      busy          <= busy_d;
      owner         <= owner_d;
      round_count   <= rc_d;
      game_done     <= done_d;
    end
  end

  // Next state, slice timing and winner latching.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    advance = 1'b0;
    mode_n  = mode_q;
    val_n   = val_q;
    load_n  = 1'b0;
    if (take) begin
      mode_n = pick[1] ? req_mode_1 : req_mode_0;
      val_n  = pick[1] ? req_value_1 : req_value_0;
      load_n = pick[1] ? req_load[1] : req_load[0];
    end
    unique case (state)
      IDLE: begin
        if (take) begin
          state_n = load_n ? LOAD : RUN;
          cnt_n   = '0;
        end
      end
      LOAD: begin
        if (cnt == LOAD_LAST) begin
          state_n = RUN;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      RUN: begin
        if (cnt == RUN_LAST) begin
          advance = 1'b1;
          cnt_n   = '0;
          state_n = (round_count == LAST_RND) ? DONE : IDLE;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      DONE: begin
        state_n = DONE;
      end
    endcase
  end

  // Output values for the coming cycle, derived from the next state.
  always_comb begin
    grant_d   = take ? pick : 2'b00;
    owner_d   = take ? pick[1] : owner;
    busy_d    = (state_n == LOAD) || (state_n == RUN);
    control_d = busy_d ? mode_n : IDLE_CODE;
    init_d    = (state_n == LOAD);
    iv_d      = init_d ? val_n : initial_value;
    rc_d      = advance ? round_count + 1'b1 : round_count;
    done_d    = (state_n == DONE);
  end

endmodule

// File: tb/tb_ctr_round_scheduler.sv
// Bench for ctr_round_scheduler: slice table with scoreboard plus corner sequences.
// A second instance runs with INIT_CYCLES=1, SLICE_CYCLES=1, MAX_ROUNDS=3.
module tb_ctr_round_scheduler;

  localparam int SLICE = 16;
  localparam int INITC = 2;
  localparam int MAXR  = 8;

  typedef struct packed {
    logic [1:0] req;
    logic [1:0] m0;
    logic [1:0] m1;
    logic [1:0] ld;
    logic [3:0] v0;
    logic [3:0] v1;
    logic [1:0] eg;
    logic       el;
    logic [1:0] em;
    logic [3:0] ev;
  } vec_t;

  logic       clock;
  logic       reset;
  logic [1:0] req;
  logic [1:0] req_mode_0;
  logic [1:0] req_mode_1;
  logic [1:0] req_load;
  logic [3:0] req_value_0;
  logic [3:0] req_value_1;
  logic [1:0] grant;
  logic [1:0] control;
  logic [3:0] initial_value;
  logic       init;
  logic       busy;
  logic       owner;
  logic [3:0] round_count;
  logic       game_done;

  logic       s_reset;
  logic [1:0] s_req;
  logic [1:0] s_grant;
  logic [1:0] s_control;
  logic [3:0] s_initial_value;
  logic       s_init;
  logic       s_busy;
  logic       s_owner;
  logic [1:0] s_round_count;
  logic       s_game_done;

  int total;
  int bad;
  int g_cnt;
  int g1_cnt;
  vec_t tab [8];
  vec_t exp_q [$];

  ctr_round_scheduler #(
    .SLICE_CYCLES (SLICE),
    .INIT_CYCLES  (INITC),
    .MAX_ROUNDS   (MAXR)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .req           (req),
    .req_mode_0    (req_mode_0),
    .req_mode_1    (req_mode_1),
    .req_load      (req_load),
    .req_value_0   (req_value_0),
    .req_value_1   (req_value_1),
    .grant         (grant),
    .control       (control),
    .initial_value (initial_value),
    .INIT          (init),
    .busy          (busy),
    .owner         (owner),
    .round_count   (round_count),
    .game_done     (game_done)
  );

  ctr_round_scheduler #(
    .SLICE_CYCLES (1),
    .INIT_CYCLES  (1),
    .MAX_ROUNDS   (3)
  ) dut_s (
    .clock         (clock),
    .reset         (s_reset),
    .req           (s_req),
    .req_mode_0    (req_mode_0),
    .req_mode_1    (req_mode_1),
    .req_load      (req_load),
    .req_value_0   (req_value_0),
    .req_value_1   (req_value_1),
    .grant         (s_grant),
    .control       (s_control),
    .initial_value (s_initial_value),
    .INIT          (s_init),
    .busy          (s_busy),
    .owner         (s_owner),
    .round_count   (s_round_count),
    .game_done     (s_game_done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (|grant) g_cnt++;
    if (grant[1]) g1_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, " grant"}, grant, 0);
    chk({nm, " control"}, control, 0);
    chk({nm, " ivalue"}, initial_value, 0);
    chk({nm, " INIT"}, init, 0);
    chk({nm, " busy"}, busy, 0);
    chk({nm, " owner"}, owner, 0);
    chk({nm, " rounds"}, round_count, 0);
    chk({nm, " done"}, game_done, 0);
  endtask

  task automatic wait_grant(output int n);
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (grant == 2'b00 && n < 40);
  endtask

  task automatic run_slice(input vec_t v, input int rc_exp);
    vec_t e;
    int n;
    req         = v.req;
    req_mode_0  = v.m0;
    req_mode_1  = v.m1;
    req_load    = v.ld;
    req_value_0 = v.v0;
    req_value_1 = v.v1;
    exp_q.push_back(v);
    wait_grant(n);
    chk("gap", n, 1);
    e = exp_q.pop_front();
    chk("grant", grant, e.eg);
    chk("owner", owner, e.eg[1]);
    if (e.el) begin
      for (int i = 0; i < INITC; i++) begin
        chk("load INIT", init, 1);
        chk("load ivalue", initial_value, e.ev);
        chk("load control", control, e.em);
        chk("load busy", busy, 1);
        if (i > 0) chk("load grant", grant, 0);
        @(negedge clock);
      end
    end
    for (int i = 0; i < SLICE; i++) begin
      chk("run INIT", init, 0);
      chk("run control", control, e.em);
      chk("run busy", busy, 1);
      chk("run ivalue", initial_value, e.ev);
      if (e.el || i > 0) chk("run grant", grant, 0);
      @(negedge clock);
    end
    chk("end control", control, 0);
    chk("end busy", busy, 0);
    chk("end INIT", init, 0);
    chk("end rounds", round_count, rc_exp);
    chk("end done", game_done, rc_exp == MAXR);
  endtask

  initial begin
    int n;
    int base;
    int errs;
    total = 0;
    bad   = 0;
    // req  m0     m1     ld     v0  v1  eg     el    em     ev
    tab[0] = '{2'b01, 2'b01, 2'b00, 2'b01, 4'd9, 4'd0,
               2'b01, 1'b1, 2'b01, 4'd9};
    tab[1] = '{2'b11, 2'b10, 2'b11, 2'b00, 4'd1, 4'd2,
               2'b10, 1'b0, 2'b11, 4'd9};
    tab[2] = '{2'b11, 2'b10, 2'b11, 2'b00, 4'd1, 4'd2,
               2'b01, 1'b0, 2'b10, 4'd9};
    tab[3] = '{2'b10, 2'b00, 2'b10, 2'b10, 4'd0, 4'd5,
               2'b10, 1'b1, 2'b10, 4'd5};
    tab[4] = '{2'b11, 2'b01, 2'b10, 2'b11, 4'd3, 4'd12,
               2'b01, 1'b1, 2'b01, 4'd3};
    tab[5] = '{2'b11, 2'b11, 2'b01, 2'b00, 4'd4, 4'd6,
               2'b10, 1'b0, 2'b01, 4'd3};
    tab[6] = '{2'b01, 2'b10, 2'b00, 2'b00, 4'd8, 4'd0,
               2'b01, 1'b0, 2'b10, 4'd3};
    tab[7] = '{2'b11, 2'b01, 2'b11, 2'b10, 4'd2, 4'd15,
               2'b10, 1'b1, 2'b11, 4'd15};

    reset       = 1'b1;
    s_reset     = 1'b1;
    s_req       = 2'b00;
    req         = 2'b00;
    req_mode_0  = 2'b00;
    req_mode_1  = 2'b00;
    req_load    = 2'b00;
    req_value_0 = 4'd0;
    req_value_1 = 4'd0;
    repeat (3) @(negedge clock);
    chk_reset("reset");
    reset = 1'b0;

    for (int i = 0; i < 8; i++)
      run_slice(tab[i], i + 1);

    base = g_cnt;
    errs = 0;
    repeat (30) begin
      @(negedge clock);
      if (control !== 2'b00 || busy !== 1'b0 || init !== 1'b0)
        errs++;
    end
    chk("done grants", g_cnt - base, 0);
    chk("done outputs", errs, 0);
    chk("done rounds", round_count, MAXR);
    chk("done flag", game_done, 1);

    reset = 1'b1;
    req   = 2'b00;
    @(negedge clock);
    reset = 1'b0;
    req        = 2'b01;
    req_mode_0 = 2'b01;
    req_load   = 2'b00;
    wait_grant(n);
    chk("wd grant0", grant, 2'b01);
    req = 2'b10;
    repeat (SLICE - 1) @(negedge clock);
    chk("wd last run", busy, 1);
    req  = 2'b00;
    base = g1_cnt;
    repeat (30) @(negedge clock);
    chk("wd no grant1", g1_cnt - base, 0);
    chk("wd rounds", round_count, 1);

    req         = 2'b11;
    req_mode_0  = 2'b01;
    req_mode_1  = 2'b10;
    req_load    = 2'b10;
    req_value_1 = 4'd6;
    wait_grant(n);
    chk("ab grant1", grant, 2'b10);
    req = 2'b00;
    repeat (INITC + 4) @(negedge clock);
    chk("ab run control", control, 2'b10);
    chk("ab run ivalue", initial_value, 6);
    chk("ab run owner", owner, 1);
    reset = 1'b1;
    @(negedge clock);
    chk_reset("abort");
    reset      = 1'b0;
    req        = 2'b11;
    req_mode_0 = 2'b11;
    req_load   = 2'b00;
    wait_grant(n);
    chk("ab rearb", grant, 2'b01);
    req = 2'b00;
    n = 0;
    while (busy && n < 40) begin
      @(negedge clock);
      n++;
    end
    chk("ab drain", busy, 0);

    req         = 2'b00;
    req_mode_0  = 2'b11;
    req_load    = 2'b01;
    req_value_0 = 4'd7;
    s_reset     = 1'b0;
    s_req       = 2'b01;
    for (int r = 0; r < 3; r++) begin
      n = 0;
      do begin
        @(negedge clock);
        n++;
      end while (s_grant == 2'b00 && n < 10);
      chk("s gap", n, 1);
      chk("s grant", s_grant, 2'b01);
      chk("s INIT", s_init, 1);
      chk("s ivalue", s_initial_value, 7);
      chk("s load ctrl", s_control, 2'b11);
      @(negedge clock);
      chk("s run INIT", s_init, 0);
      chk("s run ctrl", s_control, 2'b11);
      chk("s run busy", s_busy, 1);
      chk("s run grant", s_grant, 0);
      chk("s run rounds", s_round_count, r);
      @(negedge clock);
      chk("s idle ctrl", s_control, 2'b00);
      chk("s idle busy", s_busy, 0);
      chk("s rounds", s_round_count, r + 1);
      chk("s done", s_game_done, r == 2);
    end
    errs = 0;
    repeat (20) begin
      @(negedge clock);
      if (s_grant !== 2'b00 || s_control !== 2'b00 ||
          s_game_done !== 1'b1 || s_busy !== 1'b0)
        errs++;
    end
    chk("s done hold", errs, 0);
    chk("s final rounds", s_round_count, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
